// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port.
// Width codes are also produced by the controller/datapath that drives lshb.
// The FSM state encoding is used by data_mem_responder.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LSHB_W = 3;
  localparam int unsigned CNT_W  = 4;

  // Load/store width codes (req_lshb); 3'b101..3'b111 are illegal.
  localparam logic [LSHB_W-1:0] LS_WORD   = 3'b000;
  localparam logic [LSHB_W-1:0] LS_HALF_S = 3'b001;
  localparam logic [LSHB_W-1:0] LS_HALF_U = 3'b010;
  localparam logic [LSHB_W-1:0] LS_BYTE_S = 3'b011;
  localparam logic [LSHB_W-1:0] LS_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memState_e;

  // True for any code above the last defined width code.
  function automatic logic lsIllegal(input logic [LSHB_W-1:0] code);
    return code > LS_BYTE_U;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane alignment for one data-memory access.
// Ports:
//   lshb     - width code of the access
//   addr     - byte offset within the word (request address bits 1:0)
//   wdata    - right-aligned store data
//   rword    - full 32-bit word read from the array
//   byteEn   - lanes to write; all zero when the access is in error
//   wword    - store data replicated into every lane it may land in
//   rdata    - selected and sign/zero-extended load data; zero on error
//   misalign - misaligned address or illegal width code
module lane_align
  import mem_pkg::*;
(
  input  logic [LSHB_W-1:0] lshb,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [3:0]        byteEn,
  output logic [DATA_W-1:0] wword,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign
);

  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  // Pick the addressed half and byte out of the read word.
  always_comb begin
    halfSel = addr[1] ? rword[31:16] : rword[15:0];
    case (addr)
      2'd0:    byteSel = rword[7:0];
      2'd1:    byteSel = rword[15:8];
      2'd2:    byteSel = rword[23:16];
      default: byteSel = rword[31:24];
    endcase
  end

  // Lane enables, write replication, read extension and error detection.
  always_comb begin
    misalign = 1'b0;
    byteEn   = 4'b0000;
    wword    = wdata;
    rdata    = '0;
    case (lshb)
      LS_WORD: begin
        misalign = (addr != 2'b00);
        byteEn   = 4'b1111;
        rdata    = rword;
      end
      LS_HALF_S, LS_HALF_U: begin
        misalign = addr[0];
        byteEn   = addr[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rdata    = (lshb == LS_HALF_S) ? {{16{halfSel[15]}}, halfSel}
                                       : {16'h0000, halfSel};
      end
      LS_BYTE_S, LS_BYTE_U: begin
        byteEn = 4'b0001 << addr;
        wword  = {4{wdata[7:0]}};
        rdata  = (lshb == LS_BYTE_S) ? {{24{byteSel[7]}}, byteSel}
                                     : {24'h000000, byteSel};
      end
      default: misalign = 1'b1;
    endcase
    // Any error suppresses both the store and the load data.
    if (misalign || lsIllegal(lshb)) begin
      misalign = 1'b1;
      byteEn   = 4'b0000;
      rdata    = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data-memory port.
// Accepts one load/store in IDLE, waits WAIT_CYCLES states, then commits the
// store / samples the load on the edge entering RESP and pulses resp_valid.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req_valid/we/addr/wdata/lshb     - request from the M stage
//   req_ready                        - high only in IDLE
//   stall                            - pipeline freeze while a request is pending
//   resp_valid/resp_rdata/resp_err   - one-cycle response; data/err held afterwards
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LSHB_W-1:0] req_lshb,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_WAIT = 2'(WAIT);
  localparam logic [1:0] ST_RESP = 2'(RESP);

  localparam bit             HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = HAS_WAIT ? CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [1:0]        state, stateNext;
  logic [CNT_W-1:0]  waitCnt;
  logic [AW+1:0]     addrQ;
  logic              weQ;
  logic [DATA_W-1:0] wdataQ;
  logic [LSHB_W-1:0] lshbQ;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [AW+1:0]     curAddr;
  logic              curWe;
  logic [DATA_W-1:0] curWdata;
  logic [LSHB_W-1:0] curLshb;
  logic [AW-1:0]     curIdx;
  logic [DATA_W-1:0] rword;
  logic [3:0]        byteEn;
  logic [DATA_W-1:0] wword;
  logic [DATA_W-1:0] alignRdata;
  logic              misalign;
  logic              acceptC;
  logic              enterRespC;
  logic              unusedAddrBits;

  // Upper address bits do not take part in indexing; the array aliases.
  assign unusedAddrBits = ^req_addr[DATA_W-1:AW+2];

  // With zero wait states the commit edge is also the accept edge, so the
  // live request is used while IDLE and the latched copy afterwards.
  always_comb begin
    curAddr  = addrQ;
    curWe    = weQ;
    curWdata = wdataQ;
    curLshb  = lshbQ;
    if (state == ST_IDLE) begin
      curAddr  = req_addr[AW+1:0];
      curWe    = req_we;
      curWdata = req_wdata;
      curLshb  = req_lshb;
    end
  end

  assign curIdx = curAddr[AW+1:2];
  assign rword  = mem[curIdx];

  lane_align uAlign (
    .lshb    (curLshb),
    .addr    (curAddr[1:0]),
    .wdata   (curWdata),
    .rword   (rword),
    .byteEn  (byteEn),
    .wword   (wword),
    .rdata   (alignRdata),
    .misalign(misalign)
  );

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (req_valid) stateNext = HAS_WAIT ? ST_WAIT : ST_RESP;
      ST_WAIT: if (waitCnt == '0) stateNext = ST_RESP;
      ST_RESP: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  assign acceptC     = (state == ST_IDLE) && req_valid;
  assign enterRespC  = (stateNext == ST_RESP) && !rst;

  assign req_ready = (state == ST_IDLE);
  assign stall     = acceptC || (state == ST_WAIT);

  // State, request latch, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      waitCnt    <= '0;
      addrQ      <= '0;
      weQ        <= 1'b0;
      wdataQ     <= '0;
      lshbQ      <= LS_WORD;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= stateNext;
      resp_valid <= enterRespC;
      if (acceptC) begin
        addrQ   <= req_addr[AW+1:0];
        weQ     <= req_we;
        wdataQ  <= req_wdata;
        lshbQ   <= req_lshb;
        waitCnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (waitCnt != '0)) begin
        waitCnt <= waitCnt - CNT_W'(1);
      end
      if (enterRespC) begin
        resp_err   <= misalign;
        resp_rdata <= (curWe || misalign) ? '0 : alignRdata;
      end
    end
  end

  // Byte-lane store commit; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (enterRespC && curWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[curIdx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with none; expected responses are queued as requests are issued.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int unsigned W_A = 2;
  localparam int unsigned W_B = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, reqValidA, reqWeA, reqReadyA, stallA, respValidA, respErrA;
  logic [31:0] reqAddrA, reqWdataA, respRdataA;
  logic [2:0]  reqLshbA;
  logic        rstB, reqValidB, reqWeB, reqReadyB, stallB, respValidB, respErrB;
  logic [31:0] reqAddrB, reqWdataB, respRdataB;
  logic [2:0]  reqLshbB;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  data_mem_responder #(.DEPTH_WORDS(1024), .AW(10), .WAIT_CYCLES(W_A)) dutA (
    .clk(clk), .rst(rstA), .req_valid(reqValidA), .req_we(reqWeA),
    .req_addr(reqAddrA), .req_wdata(reqWdataA), .req_lshb(reqLshbA),
    .req_ready(reqReadyA), .stall(stallA), .resp_valid(respValidA),
    .resp_rdata(respRdataA), .resp_err(respErrA)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .AW(10), .WAIT_CYCLES(W_B)) dutB (
    .clk(clk), .rst(rstB), .req_valid(reqValidB), .req_we(reqWeB),
    .req_addr(reqAddrB), .req_wdata(reqWdataB), .req_lshb(reqLshbB),
    .req_ready(reqReadyB), .stall(stallB), .resp_valid(respValidB),
    .resp_rdata(respRdataB), .resp_err(respErrB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance A (useB=0) or B (useB=1), hold it until
  // stall drops, then check response data, error, latency and stall length.
  task automatic doReq(input bit useB, input string tag, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] lshb, input logic [31:0] expRd,
                       input logic expErr);
    exp_t e;
    int   cycles;
    int   stallCnt;
    bit   done;
    logic rv, st;
    e.rd = expRd; e.err = expErr; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    if (useB) begin
      reqValidB = 1'b1; reqWeB = we; reqAddrB = addr; reqWdataB = wdata; reqLshbB = lshb;
    end else begin
      reqValidA = 1'b1; reqWeA = we; reqAddrA = addr; reqWdataA = wdata; reqLshbA = lshb;
    end
    #1;
    cycles = 0; stallCnt = 0; done = 1'b0;
    while (!done && cycles < 40) begin
      rv = useB ? respValidB : respValidA;
      st = useB ? stallB : stallA;
      if (rv) begin
        done = 1'b1;
        reqValidA = 1'b0;
        reqValidB = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_rdata"}, useB ? respRdataB : respRdataA, e.rd);
        check({e.tag, "_err"}, 32'(useB ? respErrB : respErrA), 32'(e.err));
        check({e.tag, "_latency"}, 32'(cycles), 32'((useB ? W_B : W_A) + 1));
        check({e.tag, "_stall"}, 32'(stallCnt), 32'((useB ? W_B : W_A) + 1));
        check({e.tag, "_stall_in_resp"}, 32'(st), 32'd0);
      end else begin
        if (st) stallCnt++;
        @(negedge clk);
        #1;
        cycles++;
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      reqValidA = 1'b0;
      reqValidB = 1'b0;
    end
  endtask

  initial begin
    rstA = 1'b1; reqValidA = 1'b0; reqWeA = 1'b0; reqAddrA = '0; reqWdataA = '0; reqLshbA = LS_WORD;
    rstB = 1'b1; reqValidB = 1'b0; reqWeB = 1'b0; reqAddrB = '0; reqWdataB = '0; reqLshbB = LS_WORD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstA = 1'b0; rstB = 1'b0;
    #1;

    check("rst_ready", 32'(reqReadyA), 32'd1);
    check("rst_stall", 32'(stallA), 32'd0);
    check("rst_valid", 32'(respValidA), 32'd0);
    check("rst_rdata", respRdataA, 32'd0);
    check("rst_err", 32'(respErrA), 32'd0);

    // Basic word store / load.
    doReq(0, "sw_10", 1, 32'h10, 32'hDEADBEEF, LS_WORD, 32'h0, 0);
    doReq(0, "lw_10", 0, 32'h10, 32'h0, LS_WORD, 32'hDEADBEEF, 0);
    repeat (2) begin
      @(negedge clk); #1;
      check("hold_valid", 32'(respValidA), 32'd0);
      check("hold_rdata", respRdataA, 32'hDEADBEEF);
    end

    // Byte store into an existing word, then byte/word loads.
    doReq(0, "sw_base", 1, 32'h10, 32'h11223344, LS_WORD, 32'h0, 0);
    doReq(0, "sb_13", 1, 32'h13, 32'h00000080, LS_BYTE_S, 32'h0, 0);
    doReq(0, "lb_13", 0, 32'h13, 32'h0, LS_BYTE_S, 32'hFFFFFF80, 0);
    doReq(0, "lbu_13", 0, 32'h13, 32'h0, LS_BYTE_U, 32'h00000080, 0);
    doReq(0, "lw_10b", 0, 32'h10, 32'h0, LS_WORD, 32'h80223344, 0);
    doReq(0, "lbu_11", 0, 32'h11, 32'h0, LS_BYTE_U, 32'h00000033, 0);

    // Half store into the upper half of a zero word.
    doReq(0, "sw_20", 1, 32'h20, 32'h00000000, LS_WORD, 32'h0, 0);
    doReq(0, "sh_22", 1, 32'h22, 32'h1234BEEF, LS_HALF_S, 32'h0, 0);
    doReq(0, "lh_22", 0, 32'h22, 32'h0, LS_HALF_S, 32'hFFFFBEEF, 0);
    doReq(0, "lhu_22", 0, 32'h22, 32'h0, LS_HALF_U, 32'h0000BEEF, 0);
    doReq(0, "lhu_20", 0, 32'h20, 32'h0, LS_HALF_U, 32'h00000000, 0);

    // Errors: misaligned and illegal codes suppress stores and data.
    doReq(0, "sw_40", 1, 32'h40, 32'hCAFEF00D, LS_WORD, 32'h0, 0);
    doReq(0, "sw_41_mis", 1, 32'h41, 32'h12345678, LS_WORD, 32'h0, 1);
    doReq(0, "lh_41_mis", 0, 32'h41, 32'h0, LS_HALF_S, 32'h0, 1);
    doReq(0, "sb_40_ill", 1, 32'h40, 32'h000000AA, 3'b111, 32'h0, 1);
    doReq(0, "lw_40", 0, 32'h40, 32'h0, LS_WORD, 32'hCAFEF00D, 0);
    doReq(0, "lb_41", 0, 32'h41, 32'h0, LS_BYTE_S, 32'hFFFFFFF0, 0);
    doReq(0, "l_ill110", 0, 32'h40, 32'h0, 3'b110, 32'h0, 1);

    // Zero wait states and address aliasing on instance B.
    doReq(1, "b_sw_10", 1, 32'h10, 32'h13572468, LS_WORD, 32'h0, 0);
    doReq(1, "b_lw_alias", 0, 32'h1010, 32'h0, LS_WORD, 32'h13572468, 0);

    // Reset during the last wait state drops an uncommitted store.
    doReq(0, "sw_30", 1, 32'h30, 32'hAAAA5555, LS_WORD, 32'h0, 0);
    doReq(0, "lw_30", 0, 32'h30, 32'h0, LS_WORD, 32'hAAAA5555, 0);
    @(negedge clk);
    reqValidA = 1'b1; reqWeA = 1'b1; reqAddrA = 32'h30; reqWdataA = 32'h0BADF00D; reqLshbA = LS_WORD;
    @(negedge clk); #1;
    check("rstmid_wait1_stall", 32'(stallA), 32'd1);
    @(negedge clk); #1;
    check("rstmid_wait2_stall", 32'(stallA), 32'd1);
    rstA = 1'b1; reqValidA = 1'b0;
    @(negedge clk); #1;
    check("rstmid_ready", 32'(reqReadyA), 32'd1);
    check("rstmid_valid", 32'(respValidA), 32'd0);
    check("rstmid_stall", 32'(stallA), 32'd0);
    check("rstmid_rdata", respRdataA, 32'd0);
    check("rstmid_err", 32'(respErrA), 32'd0);
    rstA = 1'b0;
    doReq(0, "lw_30_kept", 0, 32'h30, 32'h0, LS_WORD, 32'hAAAA5555, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
